// File: rtl/rf_access_ctrl_pkg.sv
// Shared opcode, FSM state encodings and sizing helper for rf_access_ctrl.
package rf_access_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_CLEAR = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StClear,
        StResp
    } state_e;

    // Keeps index ports at least one bit wide for a single-entry file.
    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/rf_access_ctrl.sv
// Command/response front end for a register file: single reads, single writes,
// a full clear sweep, and error responses for reserved ops or out-of-range indices.
module rf_access_ctrl
    import rf_access_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [AW-1:0]    cmd_addr,
    input  logic [WIDTH-1:0] cmd_wdata,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_err,
    output logic             busy,

    output logic             rf_we,
    output logic [AW-1:0]    rf_write_reg,
    output logic [WIDTH-1:0] rf_write_data,
    output logic [AW-1:0]    rf_read_reg,
    input  logic [WIDTH-1:0] rf_read_data
);

    localparam logic [AW:0] DEPTH_W   = (AW+1)'(DEPTH);
    localparam logic [AW:0] CLR_LAST  = (AW+1)'(DEPTH - 1);

    state_e           state_q, state_d;
    logic [AW-1:0]    wr_reg_q, wr_reg_d;
    logic [WIDTH-1:0] wr_data_q, wr_data_d;
    logic [AW-1:0]    rd_reg_q, rd_reg_d;
    logic [AW:0]      clr_cnt_q, clr_cnt_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic             rsp_err_q, rsp_err_d;

    op_e  op;
    logic addr_bad;

    assign op       = op_e'(cmd_op);
    assign addr_bad = ({1'b0, cmd_addr} >= DEPTH_W);

    always_comb begin
        state_d     = state_q;
        wr_reg_d    = wr_reg_q;
        wr_data_d   = wr_data_q;
        rd_reg_d    = rd_reg_q;
        clr_cnt_d   = clr_cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        unique case (state_q)
            StIdle: begin
                rd_reg_d = cmd_addr;
                if (cmd_valid) begin
                    if (op == OP_RSVD || addr_bad) begin
                        state_d     = StResp;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        unique case (op)
                            OP_READ: begin
                                state_d     = StResp;
                                rsp_valid_d = 1'b1;
                                rsp_err_d   = 1'b0;
                                rsp_rdata_d = rf_read_data;
                            end
                            OP_WRITE: begin
                                state_d   = StWrite;
                                wr_reg_d  = cmd_addr;
                                wr_data_d = cmd_wdata;
                            end
                            OP_CLEAR: begin
                                state_d   = StClear;
                                wr_reg_d  = '0;
                                wr_data_d = '0;
                                clr_cnt_d = '0;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            StWrite: begin
                state_d     = StResp;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = '0;
            end
            StClear: begin
                // Wide counter: terminal count is compared without wrapping into index 0.
                if (clr_cnt_q == CLR_LAST) begin
                    state_d     = StResp;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                    wr_reg_d  = clr_cnt_d[AW-1:0];
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            wr_reg_q    <= '0;
            wr_data_q   <= '0;
            rd_reg_q    <= '0;
            clr_cnt_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_reg_q    <= wr_reg_d;
            wr_data_q   <= wr_data_d;
            rd_reg_q    <= rd_reg_d;
            clr_cnt_q   <= clr_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // rf_we is decoded from state so an asynchronous reset drops it at once.
    assign cmd_ready     = (state_q == StIdle) && !rst;
    assign busy          = (state_q != StIdle);
    assign rf_we         = (state_q == StWrite) || (state_q == StClear);
    assign rf_write_reg  = wr_reg_q;
    assign rf_write_data = wr_data_q;
    assign rf_read_reg   = (state_q == StIdle) ? cmd_addr : rd_reg_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_err       = rsp_err_q;

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Bench for rf_access_ctrl: directed vector table, corner sequences and random
// traffic checked against a transaction-level register-file model.
module tb_rf_access_ctrl;

    localparam int W  = 16;
    localparam int D  = 8;
    localparam int AW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          cmd_valid, cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [W-1:0]  cmd_wdata;
    logic          rsp_valid, rsp_ready, rsp_err, busy;
    logic [W-1:0]  rsp_rdata;
    logic          rf_we;
    logic [AW-1:0] rf_write_reg, rf_read_reg;
    logic [W-1:0]  rf_write_data, rf_read_data;

    rf_access_ctrl #(.WIDTH(W), .DEPTH(D)) u_dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy),
        .rf_we(rf_we), .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
        .rf_read_reg(rf_read_reg), .rf_read_data(rf_read_data)
    );

    // Attached register file: synchronous write, asynchronous read, no reset.
    logic [W-1:0] rf_mem [D];
    always @(posedge clk) if (rf_we) rf_mem[rf_write_reg] <= rf_write_data;
    assign rf_read_data = rf_mem[rf_read_reg];

    // Second instance with a non-power-of-two depth for out-of-range indices.
    logic          d6_cmd_valid, d6_cmd_ready, d6_rsp_valid, d6_rsp_ready, d6_rsp_err, d6_busy;
    logic [1:0]    d6_cmd_op;
    logic [AW-1:0] d6_cmd_addr, d6_rf_write_reg, d6_rf_read_reg;
    logic [W-1:0]  d6_cmd_wdata, d6_rsp_rdata, d6_rf_write_data, d6_rf_read_data;
    logic          d6_rf_we;

    rf_access_ctrl #(.WIDTH(W), .DEPTH(6)) u_dut6 (
        .clk(clk), .rst(rst),
        .cmd_valid(d6_cmd_valid), .cmd_ready(d6_cmd_ready), .cmd_op(d6_cmd_op),
        .cmd_addr(d6_cmd_addr), .cmd_wdata(d6_cmd_wdata),
        .rsp_valid(d6_rsp_valid), .rsp_ready(d6_rsp_ready), .rsp_rdata(d6_rsp_rdata),
        .rsp_err(d6_rsp_err), .busy(d6_busy),
        .rf_we(d6_rf_we), .rf_write_reg(d6_rf_write_reg), .rf_write_data(d6_rf_write_data),
        .rf_read_reg(d6_rf_read_reg), .rf_read_data(d6_rf_read_data)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Results of the most recent transaction on u_dut.
    int           we_idx[$];
    logic [W-1:0] we_dat[$];
    logic [W-1:0] r_rdata;
    logic         r_err;
    int           r_lat;
    bit           r_ok;
    int           hold_bad;

    task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] addr,
                           input logic [W-1:0] wd, input int hold);
        int n;
        we_idx.delete();
        we_dat.delete();
        r_ok = 0; r_lat = 0; hold_bad = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wd;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        if (!cmd_ready) begin chk("accept_timeout", 0, 1); cmd_valid = 1'b0; return; end
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 4 * D) begin
            if (rf_we) begin
                we_idx.push_back(int'(rf_write_reg));
                we_dat.push_back(rf_write_data);
            end
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) begin chk("rsp_timeout", 0, 1); return; end
        r_ok = 1; r_lat = n; r_rdata = rsp_rdata; r_err = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_rdata !== r_rdata || rsp_err !== r_err ||
                cmd_ready !== 1'b0 || rf_we !== 1'b0) hold_bad++;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    // Transaction-level reference: what each command must do to the file.
    logic [W-1:0] exp_mem [D];

    function automatic bit is_err(input logic [1:0] op, input logic [AW-1:0] addr);
        return (op == 2'b11) || (int'(addr) >= D);
    endfunction

    task automatic update_model(input logic [1:0] op, input logic [AW-1:0] addr,
                                input logic [W-1:0] wd);
        if (is_err(op, addr)) return;
        if (op == 2'b01) exp_mem[addr] = wd;
        if (op == 2'b10) for (int i = 0; i < D; i++) exp_mem[i] = '0;
    endtask

    task automatic check_model(input string tag, input logic [1:0] op,
                               input logic [AW-1:0] addr, input logic [W-1:0] wd);
        bit           e;
        int           nwe, lat, bad;
        logic [W-1:0] rd;
        e   = is_err(op, addr);
        nwe = e ? 0 : (op == 2'b01) ? 1 : (op == 2'b10) ? D : 0;
        lat = e ? 1 : (op == 2'b01) ? 2 : (op == 2'b10) ? D + 1 : 1;
        rd  = (!e && op == 2'b00) ? exp_mem[addr] : '0;
        if (r_ok) begin
            chk({tag, "_err"}, r_err, e);
            chk({tag, "_rdata"}, r_rdata, rd);
            chk({tag, "_latency"}, r_lat, lat);
            chk({tag, "_nwe"}, we_idx.size(), nwe);
            bad = 0;
            for (int i = 0; i < we_idx.size() && i < nwe; i++) begin
                if (we_idx[i] != ((op == 2'b10) ? i : int'(addr))) bad++;
                if (we_dat[i] !== ((op == 2'b10) ? '0 : wd)) bad++;
            end
            chk({tag, "_we_seq"}, bad, 0);
        end
        update_model(op, addr, wd);
    endtask

    typedef struct {
        logic [1:0]    op;
        logic [AW-1:0] addr;
        logic [W-1:0]  wd;
        logic [W-1:0]  rd;
        logic          err;
        int            nwe;
        int            lat;
    } vec_t;

    vec_t vecs [11];

    task automatic run6(input logic [1:0] op, input logic [AW-1:0] addr, input logic [W-1:0] wd,
                        output logic [W-1:0] rd, output logic er, output int nwe);
        int n;
        nwe = 0;
        @(negedge clk);
        d6_cmd_valid = 1'b1; d6_cmd_op = op; d6_cmd_addr = addr; d6_cmd_wdata = wd;
        n = 0;
        while (!d6_cmd_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        d6_cmd_valid = 1'b0;
        n = 0;
        while (!d6_rsp_valid && n < 50) begin
            if (d6_rf_we) nwe++;
            @(negedge clk);
            n++;
        end
        if (!d6_rsp_valid) chk("d6_rsp_timeout", 0, 1);
        rd = d6_rsp_rdata;
        er = d6_rsp_err;
        d6_rsp_ready = 1'b1;
        @(negedge clk);
        d6_rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]    op;
        logic [AW-1:0] addr;
        logic [W-1:0]  wd, rd6;
        logic          er6;
        int            n6, bad;

        vecs[0]  = '{2'b10, 3'd0, 16'h0000, 16'h0000, 1'b0, 8, 9};
        vecs[1]  = '{2'b01, 3'd3, 16'hA5A5, 16'h0000, 1'b0, 1, 2};
        vecs[2]  = '{2'b00, 3'd3, 16'h0000, 16'hA5A5, 1'b0, 0, 1};
        vecs[3]  = '{2'b11, 3'd3, 16'hFFFF, 16'h0000, 1'b1, 0, 1};
        vecs[4]  = '{2'b00, 3'd3, 16'h0000, 16'hA5A5, 1'b0, 0, 1};
        vecs[5]  = '{2'b01, 3'd7, 16'h1234, 16'h0000, 1'b0, 1, 2};
        vecs[6]  = '{2'b00, 3'd7, 16'h0000, 16'h1234, 1'b0, 0, 1};
        vecs[7]  = '{2'b00, 3'd0, 16'h0000, 16'h0000, 1'b0, 0, 1};
        vecs[8]  = '{2'b01, 3'd0, 16'hFFFF, 16'h0000, 1'b0, 1, 2};
        vecs[9]  = '{2'b00, 3'd0, 16'h0000, 16'hFFFF, 1'b0, 0, 1};
        vecs[10] = '{2'b11, 3'd0, 16'h0000, 16'h0000, 1'b1, 0, 1};

        rst = 1'b1;
        cmd_valid = 1'b0; cmd_op = '0; cmd_addr = 3'd5; cmd_wdata = '0; rsp_ready = 1'b0;
        d6_cmd_valid = 1'b0; d6_cmd_op = '0; d6_cmd_addr = '0; d6_cmd_wdata = '0;
        d6_rsp_ready = 1'b0; d6_rf_read_data = 16'h5A5A;

        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_write_reg", rf_write_reg, 0);
        chk("rst_rf_write_data", rf_write_data, 0);
        chk("rst_rf_read_reg", rf_read_reg, 5);
        rst = 1'b0;
        cmd_addr = 3'd0;
        @(negedge clk);
        chk("post_rst_cmd_ready", cmd_ready, 1);

        for (int i = 0; i < 11; i++) begin
            run_cmd(vecs[i].op, vecs[i].addr, vecs[i].wd, 0);
            chk($sformatf("vec%0d_ok", i), r_ok, 1);
            chk($sformatf("vec%0d_rdata", i), r_rdata, vecs[i].rd);
            chk($sformatf("vec%0d_err", i), r_err, vecs[i].err);
            chk($sformatf("vec%0d_nwe", i), we_idx.size(), vecs[i].nwe);
            chk($sformatf("vec%0d_lat", i), r_lat, vecs[i].lat);
            if (vecs[i].op == 2'b01 && we_idx.size() > 0)
                chk($sformatf("vec%0d_we_idx", i), we_idx[0], int'(vecs[i].addr));
            update_model(vecs[i].op, vecs[i].addr, vecs[i].wd);
        end

        // Fill with distinct values, clear, and read every entry back.
        for (int i = 0; i < D; i++) begin
            run_cmd(2'b01, AW'(i), W'(16'h1000 + i * 16'h0111), 0);
            check_model("fill", 2'b01, AW'(i), W'(16'h1000 + i * 16'h0111));
        end
        run_cmd(2'b10, 3'd0, 16'h0, 0);
        check_model("clear", 2'b10, 3'd0, 16'h0);
        for (int i = 0; i < D; i++) begin
            run_cmd(2'b00, AW'(i), 16'h0, 0);
            check_model("clear_read", 2'b00, AW'(i), 16'h0);
        end

        // Response held off for five cycles.
        run_cmd(2'b01, 3'd2, 16'hBEEF, 0);
        check_model("hold_wr", 2'b01, 3'd2, 16'hBEEF);
        run_cmd(2'b00, 3'd2, 16'h0, 5);
        check_model("hold_rd", 2'b00, 3'd2, 16'h0);
        chk("hold_stable", hold_bad, 0);
        chk("hold_release_busy", busy, 0);
        chk("hold_release_ready", cmd_ready, 1);
        chk("hold_release_valid", rsp_valid, 0);

        for (int t = 0; t < 150; t++) begin
            n6   = int'($urandom_range(0, 9));
            op   = (n6 < 4) ? 2'b00 : (n6 < 7) ? 2'b01 : (n6 < 8) ? 2'b10 : 2'b11;
            addr = AW'($urandom_range(0, D - 1));
            wd   = W'($urandom);
            run_cmd(op, addr, wd, int'($urandom_range(0, 2)));
            check_model($sformatf("rnd%0d", t), op, addr, wd);
        end

        // Reset in the fourth cycle of a clear sweep.
        for (int i = 0; i < D; i++) begin
            run_cmd(2'b01, AW'(i), W'(16'hC000 + i), 0);
            check_model("pre_abort", 2'b01, AW'(i), W'(16'hC000 + i));
        end
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_addr = 3'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_pre_we", rf_we, 1);
        chk("abort_pre_idx", rf_write_reg, 3);
        rst = 1'b1;
        cmd_addr = 3'd6;
        #1;
        chk("abort_we_drop", rf_we, 0);
        chk("abort_busy", busy, 0);
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_read_reg", rf_read_reg, 6);
        @(negedge clk);
        rst = 1'b0;
        cmd_addr = 3'd0;
        for (int i = 0; i < 3; i++) exp_mem[i] = '0;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) bad++;
        end
        chk("abort_no_rsp", bad, 0);
        for (int i = 0; i < D; i++) begin
            run_cmd(2'b00, AW'(i), 16'h0, 0);
            check_model("abort_read", 2'b00, AW'(i), 16'h0);
        end

        // DEPTH = 6 instance: indices 6 and 7 are out of range.
        run6(2'b01, 3'd7, 16'h7777, rd6, er6, n6);
        chk("d6_wr7_err", er6, 1);
        chk("d6_wr7_nwe", n6, 0);
        chk("d6_wr7_rdata", rd6, 0);
        run6(2'b00, 3'd6, 16'h0, rd6, er6, n6);
        chk("d6_rd6_err", er6, 1);
        chk("d6_rd6_rdata", rd6, 0);
        run6(2'b01, 3'd5, 16'hABCD, rd6, er6, n6);
        chk("d6_wr5_err", er6, 0);
        chk("d6_wr5_nwe", n6, 1);
        run6(2'b10, 3'd0, 16'h0, rd6, er6, n6);
        chk("d6_clear_nwe", n6, 6);
        chk("d6_clear_err", er6, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
